// File: rtl/gpio_port.sv
// gpio_port: register-mapped GPIO port with two-flop input sync.
// Define GPIO_IRQ_EN to build edge interrupts and registers 5-7 (IRQ_MASK, IRQ_EDGE, IRQ_STAT).
module gpio_port #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       addr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             we,
  input  logic             re,
  output logic [WIDTH-1:0] rdata,
  output logic [WIDTH-1:0] iosel,
  output logic [WIDTH-1:0] out,
  input  logic [WIDTH-1:0] in,
  output logic             irq
);
  logic [WIDTH-1:0] s1, s2, irq_rd, rd_mux;
  assign rd_mux = addr == 3'd0 ? iosel : addr == 3'd1 ? out : addr == 3'd2 ? s2 : irq_rd;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      iosel <= '0;
      out   <= '0;
      s1    <= '0;
      s2    <= '0;
      rdata <= '0;
    end else begin
      s1 <= in;
      s2 <= s1;
      if (we && addr == 3'd0) iosel <= wdata;
      if (we) out <= addr == 3'd1 ? wdata : addr == 3'd3 ? out | wdata : addr == 3'd4 ? out & ~wdata : out;
      if (re && !we) rdata <= rd_mux;
    end
  end
`ifdef GPIO_IRQ_EN
  logic [WIDTH-1:0] d3, mask, pol, stat, hit;
  logic [1:0]       warm;
  // edges are ignored until warm saturates, so pins already high at reset release stay quiet
  assign hit    = warm == 2'd3 ? ((s2 & ~d3 & ~pol) | (~s2 & d3 & pol)) : '0;
  assign irq_rd = addr == 3'd5 ? mask : addr == 3'd6 ? pol : addr == 3'd7 ? stat : '0;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      d3   <= '0;
      mask <= '0;
      pol  <= '0;
      stat <= '0;
      warm <= '0;
      irq  <= 1'b0;
    end else begin
      d3   <= s2;
      warm <= warm == 2'd3 ? warm : warm + 2'd1;
      if (we && addr == 3'd5) mask <= wdata;
      if (we && addr == 3'd6) pol <= wdata;
      stat <= (stat & ~(we && addr == 3'd7 ? wdata : '0)) | hit;
      irq  <= |(stat & mask);
    end
  end
`else
  assign irq_rd = '0;
  assign irq    = 1'b0;
`endif
endmodule

// File: tb/tb_gpio_port.sv
// tb_gpio_port: directed stimulus checked every cycle against a register-file model of the port.
module tb_gpio_port;
  localparam int W = 8;
`ifdef GPIO_IRQ_EN
  localparam bit IRQ = 1'b1;
`else
  localparam bit IRQ = 1'b0;
`endif
  logic         clk = 1'b0, rst = 1'b1, we = 1'b0, re = 1'b0, irq;
  logic [2:0]   addr = '0;
  logic [W-1:0] wdata = '0, in = '0, rdata, iosel, out, v;
  int           checks = 0, fails = 0;

  gpio_port #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .addr(addr), .wdata(wdata), .we(we), .re(re),
    .rdata(rdata), .iosel(iosel), .out(out), .in(in), .irq(irq)
  );

  always #5 clk = ~clk;

  // model: registers by address, pin history newest-first, edges counted since reset
  logic [W-1:0] m_reg [8];
  logic [W-1:0] hist [$];
  logic [W-1:0] m_rdata, m_in, m_prev, hits;
  logic         m_irq;
  int           age;

  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      foreach (m_reg[i]) m_reg[i] = '0;
      m_rdata = '0;
      m_irq   = 1'b0;
      age     = 0;
      hist.delete();
      repeat (3) hist.push_back('0);
    end else begin
      m_in   = hist[1];
      m_prev = hist[2];
      hits   = age >= 3 ? ((m_in & ~m_prev & ~m_reg[6]) | (~m_in & m_prev & m_reg[6])) : '0;
      if (re && !we) m_rdata = addr == 3'd2 ? m_in : m_reg[addr];
      m_irq = IRQ && (|(m_reg[7] & m_reg[5]));
      if (we)
        case (addr)
          3'd0, 3'd1, 3'd5, 3'd6: m_reg[addr] = wdata;
          3'd3: m_reg[1] = m_reg[1] | wdata;
          3'd4: m_reg[1] = m_reg[1] & ~wdata;
          3'd7: m_reg[7] = m_reg[7] & ~wdata;
          default: ;
        endcase
      m_reg[7] = m_reg[7] | hits;
      if (!IRQ) begin
        m_reg[5] = '0;
        m_reg[6] = '0;
        m_reg[7] = '0;
      end
      hist.push_front(in);
      void'(hist.pop_back());
      age++;
    end
  end

  task automatic cmp(input string n, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, got, exp, $time);
    end
  endtask

  initial forever begin
    @(negedge clk);
    cmp("iosel", iosel, m_reg[0]);
    cmp("out", out, m_reg[1]);
    cmp("rdata", rdata, m_rdata);
    cmp("irq", irq, m_irq);
  end

  task automatic step;
    @(posedge clk);
    #2;
  endtask

  task automatic wr(input logic [2:0] a, input logic [W-1:0] d);
    addr = a; wdata = d; we = 1'b1;
    step();
    we = 1'b0;
  endtask

  task automatic rd(input logic [2:0] a, output logic [W-1:0] d);
    addr = a; re = 1'b1;
    step();
    re = 1'b0;
    d = rdata;
  endtask

  initial begin
    in = 8'hFF;
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    cmp("rst_iosel", iosel, 0);
    cmp("rst_out", out, 0);
    cmp("rst_rdata", rdata, 0);
    cmp("rst_irq", irq, 0);
    step(); step();
    rd(3'd2, v); cmp("in_after_rst", v, 8'hFF);
    repeat (3) step();
    rd(3'd7, v); cmp("no_false_edge", v, 0);
    wr(3'd0, 8'hF0); cmp("dir_iosel", iosel, 8'hF0);
    wr(3'd1, 8'hA5); cmp("out_a5", out, 8'hA5);
    wr(3'd1, 8'h0F); wr(3'd3, 8'h30); wr(3'd4, 8'h01);
    rd(3'd1, v); cmp("set_clr", v, 8'h3E);
    rd(3'd3, v); cmp("set_reads_0", v, 0);
    rd(3'd4, v); cmp("clr_reads_0", v, 0);
    rd(3'd0, v); cmp("dir_read", v, 8'hF0);
    addr = 3'd1; wdata = 8'h55; we = 1'b1; re = 1'b1;
    step();
    we = 1'b0; re = 1'b0;
    cmp("rw_rdata_held", rdata, 8'hF0);
    cmp("rw_write_done", out, 8'h55);
    in = 8'h00;
    repeat (4) step();
    wr(3'd6, 8'h00); wr(3'd5, 8'h04);
    in = 8'h04;
    step(); step();
    cmp("irq_pre", irq, 0);
    step();
    rd(3'd7, v); cmp("stat_rise", v, IRQ ? 8'h04 : 8'h00);
    cmp("irq_set", irq, IRQ);
    wr(3'd7, 8'h04);
    step();
    cmp("irq_clr", irq, 0);
    in = 8'h00; repeat (4) step();
    in = 8'h04; repeat (4) step();
    in = 8'h00; repeat (4) step();
    in = 8'h04; step(); step();
    wr(3'd7, 8'h04);
    rd(3'd7, v); cmp("w1c_vs_edge", v, IRQ ? 8'h04 : 8'h00);
    wr(3'd7, 8'h04); wr(3'd6, 8'h04);
    in = 8'h00; repeat (3) step();
    rd(3'd7, v); cmp("stat_fall", v, IRQ ? 8'h04 : 8'h00);
    rd(3'd6, v); cmp("edge_read", v, IRQ ? 8'h04 : 8'h00);
    wr(3'd7, 8'hFF);
    in = out; step(); step();
    rd(3'd2, v); cmp("in_readback", v, 8'h55);
    in = 8'h00;
    wr(3'd0, 8'hFF); cmp("dir_ff", iosel, 8'hFF);
    rst = 1'b1;
    #1 cmp("rst_async_iosel", iosel, 0);
    @(posedge clk);
    #2 rst = 1'b0;
    for (int a = 0; a < 8; a++) begin
      rd(a[2:0], v);
      cmp("post_rst_reg", v, 0);
    end
    step();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
